// File: rtl/dual_issue_ctrl.sv
// Issue-stage scheduler for a 2-wide RV32I pipeline.
// Takes an aligned instruction pair from fetch and issues it either as a pair
// (independent, resource-compatible) or split over two cycles, holding the
// younger instruction in a one-entry buffer. Slot0 owns branch and LSU;
// slot1 is ALU/LUI/AUIPC only.
module dual_issue_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  input  logic            in_valid1,
  input  logic [XLEN-1:0] in_instr0,
  input  logic [XLEN-1:0] in_instr1,
  input  logic [XLEN-1:0] in_pc,
  output logic            in_ready,
  input  logic            iss_ready,
  output logic            iss0_valid,
  output logic [XLEN-1:0] iss0_instr,
  output logic [XLEN-1:0] iss0_pc,
  output logic            iss1_valid,
  output logic [XLEN-1:0] iss1_instr,
  output logic [XLEN-1:0] iss1_pc,
  output logic [CNT_W-1:0] cnt_dual,
  output logic [CNT_W-1:0] cnt_single
);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic {NORMAL, HOLD} state_t;

  // ---------------------------------------------------------------------------
  // Opcode classification; unknown opcodes fall out as plain ALU with no
  // register sources and no destination, so they never create hazards.
  // ---------------------------------------------------------------------------
  function automatic logic f_uses_rs1(input logic [6:0] op);
    return (op == OP_REG) || (op == OP_IMM) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JALR);
  endfunction

  function automatic logic f_uses_rs2(input logic [6:0] op);
    return (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  function automatic logic f_writes_rd(input logic [6:0] op, input logic [4:0] rd);
    return (rd != 5'd0) &&
           ((op == OP_REG) || (op == OP_IMM) || (op == OP_LOAD) ||
            (op == OP_JALR) || (op == OP_JAL) || (op == OP_LUI) ||
            (op == OP_AUIPC));
  endfunction

  function automatic logic f_is_mem(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic logic f_is_ctrl(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t            r_state;
  logic              r_v0, r_v1;
  logic [XLEN-1:0]   r_i0, r_p0, r_i1, r_p1;
  logic [XLEN-1:0]   r_hold_instr, r_hold_pc;
  logic [CNT_W-1:0]  r_cnt_dual, r_cnt_single;

  // ---------------------------------------------------------------------------
  // Pair decode
  // ---------------------------------------------------------------------------
  logic [6:0]      w_op0, w_op1;
  logic [4:0]      w_rd0, w_rd1, w_rs1_1, w_rs2_1;
  logic            w_wr0, w_wr1;
  logic            w_raw, w_waw, w_can_pair;
  logic            w_adv;
  logic [XLEN-1:0] w_pc1;

  assign w_op0   = in_instr0[6:0];
  assign w_op1   = in_instr1[6:0];
  assign w_rd0   = in_instr0[11:7];
  assign w_rd1   = in_instr1[11:7];
  assign w_rs1_1 = in_instr1[19:15];
  assign w_rs2_1 = in_instr1[24:20];
  assign w_wr0   = f_writes_rd(w_op0, w_rd0);
  assign w_wr1   = f_writes_rd(w_op1, w_rd1);
  assign w_raw   = w_wr0 && ((f_uses_rs1(w_op1) && (w_rs1_1 == w_rd0)) ||
                             (f_uses_rs2(w_op1) && (w_rs2_1 == w_rd0)));
  assign w_waw   = w_wr0 && w_wr1 && (w_rd0 == w_rd1);
  assign w_can_pair = in_valid1 && !w_raw && !w_waw && !f_is_ctrl(w_op0) &&
                      !f_is_mem(w_op1) && !f_is_ctrl(w_op1);

  // PC of the younger instruction wraps modulo 2^XLEN by construction.
  assign w_pc1 = in_pc + XLEN'(4);

  // Issue register may load when empty or when execute takes its contents.
  assign w_adv = !r_v0 || iss_ready;

  // ---------------------------------------------------------------------------
  // Next-state / next-issue logic
  // ---------------------------------------------------------------------------
  state_t          w_state_nxt;
  logic            w_v0_nxt, w_v1_nxt;
  logic [XLEN-1:0] w_i0_nxt, w_p0_nxt, w_i1_nxt, w_p1_nxt;
  logic            w_hold_ld;

  // Decide what the issue register and the hold buffer capture this cycle.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_v0_nxt    = r_v0;
    w_v1_nxt    = r_v1;
    w_i0_nxt    = r_i0;
    w_p0_nxt    = r_p0;
    w_i1_nxt    = r_i1;
    w_p1_nxt    = r_p1;
    w_hold_ld   = 1'b0;
    if (flush) begin
      // Flush wins over backpressure and kills everything in flight.
      w_state_nxt = NORMAL;
      w_v0_nxt    = 1'b0;
      w_v1_nxt    = 1'b0;
    end else if (w_adv) begin
      unique case (r_state)
        NORMAL: begin
          in_ready = 1'b1;
          if (in_valid) begin
            w_v0_nxt = 1'b1;
            w_i0_nxt = in_instr0;
            w_p0_nxt = in_pc;
            if (w_can_pair) begin
              w_v1_nxt = 1'b1;
              w_i1_nxt = in_instr1;
              w_p1_nxt = w_pc1;
            end else begin
              w_v1_nxt = 1'b0;
              if (in_valid1) begin
                w_hold_ld   = 1'b1;
                w_state_nxt = HOLD;
              end
            end
          end else begin
            w_v0_nxt = 1'b0;
            w_v1_nxt = 1'b0;
          end
        end
        HOLD: begin
          // Held instruction always issues alone; fetch stays stalled.
          w_v0_nxt    = 1'b1;
          w_i0_nxt    = r_hold_instr;
          w_p0_nxt    = r_hold_pc;
          w_v1_nxt    = 1'b0;
          w_state_nxt = NORMAL;
        end
        default: w_state_nxt = NORMAL;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= NORMAL;
    else        r_state <= w_state_nxt;
  end

  // Issue register; holds stable while execute applies backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
      r_i0 <= '0;
      r_p0 <= '0;
      r_i1 <= '0;
      r_p1 <= '0;
    end else begin
      r_v0 <= w_v0_nxt;
      r_v1 <= w_v1_nxt;
      r_i0 <= w_i0_nxt;
      r_p0 <= w_p0_nxt;
      r_i1 <= w_i1_nxt;
      r_p1 <= w_p1_nxt;
    end
  end

  // One-entry hold buffer for the younger instruction of a split pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_instr <= '0;
      r_hold_pc    <= '0;
    end else if (flush) begin
      r_hold_instr <= '0;
      r_hold_pc    <= '0;
    end else if (w_hold_ld) begin
      r_hold_instr <= in_instr1;
      r_hold_pc    <= w_pc1;
    end
  end

  // Issue-width performance counters; free-running, survive flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_dual   <= '0;
      r_cnt_single <= '0;
    end else if (w_adv && !flush) begin
      if (w_v0_nxt && w_v1_nxt)
        r_cnt_dual <= r_cnt_dual + CNT_W'(1);
      else if (w_v0_nxt ^ w_v1_nxt)
        r_cnt_single <= r_cnt_single + CNT_W'(1);
    end
  end

  assign iss0_valid = r_v0;
  assign iss0_instr = r_i0;
  assign iss0_pc    = r_p0;
  assign iss1_valid = r_v1;
  assign iss1_instr = r_i1;
  assign iss1_pc    = r_p1;
  assign cnt_dual   = r_cnt_dual;
  assign cnt_single = r_cnt_single;

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Scoreboard bench for dual_issue_ctrl: a rule-level reference model predicts
// the issue register after every clock edge, a monitor compares.
module tb_dual_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, in_valid1, iss_ready;
  logic [31:0] in_instr0, in_instr1, in_pc;
  logic        in_ready, iss0_valid, iss1_valid;
  logic [31:0] iss0_instr, iss0_pc, iss1_instr, iss1_pc, cnt_dual, cnt_single;

  int checks = 0;
  int errors = 0;

  dual_issue_ctrl #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_valid1(in_valid1),
    .in_instr0(in_instr0), .in_instr1(in_instr1), .in_pc(in_pc),
    .in_ready(in_ready), .iss_ready(iss_ready),
    .iss0_valid(iss0_valid), .iss0_instr(iss0_instr), .iss0_pc(iss0_pc),
    .iss1_valid(iss1_valid), .iss1_instr(iss1_instr), .iss1_pc(iss1_pc),
    .cnt_dual(cnt_dual), .cnt_single(cnt_single)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---- reference model: instruction properties from the ISA rules ----------
  typedef struct {
    bit r1, r2, wr, mem, ctrl;
    logic [4:0] rd, rs1, rs2;
  } cls_t;

  function automatic cls_t classify(input logic [31:0] ins);
    cls_t c;
    logic [6:0] op;
    op = ins[6:0];
    c.rd = ins[11:7]; c.rs1 = ins[19:15]; c.rs2 = ins[24:20];
    c.r1 = op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
    c.r2 = op inside {7'h33, 7'h23, 7'h63};
    c.wr = (c.rd != 0) && (op inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h6F, 7'h37, 7'h17});
    c.mem  = op inside {7'h03, 7'h23};
    c.ctrl = op inside {7'h63, 7'h6F, 7'h67};
    return c;
  endfunction

  function automatic bit pairable(input logic [31:0] a, input logic [31:0] b);
    cls_t x, y;
    x = classify(a);
    y = classify(b);
    if (x.wr && y.r1 && y.rs1 == x.rd) return 0;
    if (x.wr && y.r2 && y.rs2 == x.rd) return 0;
    if (x.wr && y.wr && x.rd == y.rd) return 0;
    if (x.ctrl || y.mem || y.ctrl) return 0;
    return 1;
  endfunction

  typedef struct {
    bit v0, v1;
    logic [31:0] i0, p0, i1, p1, cd, cs;
  } exp_t;

  typedef struct { logic [31:0] ins, pc; } held_t;

  exp_t  sb_q[$];
  held_t held_q[$];
  bit          m_v0, m_v1;
  logic [31:0] m_i0, m_p0, m_i1, m_p1;
  int unsigned m_cd, m_cs;

  // Model the issue register one edge at a time and queue the prediction.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v0 = 0; m_v1 = 0; m_cd = 0; m_cs = 0;
      m_i0 = 0; m_p0 = 0; m_i1 = 0; m_p1 = 0;
      held_q.delete();
      sb_q.delete();
    end else begin
      if (flush) begin
        m_v0 = 0; m_v1 = 0;
        held_q.delete();
      end else if (!m_v0 || iss_ready) begin
        if (held_q.size() > 0) begin
          held_t h;
          h = held_q.pop_front();
          m_v0 = 1; m_i0 = h.ins; m_p0 = h.pc; m_v1 = 0;
          m_cs++;
        end else if (in_valid) begin
          m_v0 = 1; m_i0 = in_instr0; m_p0 = in_pc;
          if (in_valid1 && pairable(in_instr0, in_instr1)) begin
            m_v1 = 1; m_i1 = in_instr1; m_p1 = in_pc + 4;
            m_cd++;
          end else begin
            m_v1 = 0;
            m_cs++;
            if (in_valid1) held_q.push_back('{in_instr1, in_pc + 32'd4});
          end
        end else begin
          m_v0 = 0; m_v1 = 0;
        end
      end
      sb_q.push_back('{m_v0, m_v1, m_i0, m_p0, m_i1, m_p1, m_cd, m_cs});
    end
  end

  // Monitor: compare the registered outputs just after each active edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("iss0_valid", {31'd0, iss0_valid}, {31'd0, e.v0});
      chk("iss1_valid", {31'd0, iss1_valid}, {31'd0, e.v1});
      if (e.v0) begin
        chk("iss0_instr", iss0_instr, e.i0);
        chk("iss0_pc", iss0_pc, e.p0);
      end
      if (e.v1) begin
        chk("iss1_instr", iss1_instr, e.i1);
        chk("iss1_pc", iss1_pc, e.p1);
      end
      chk("cnt_dual", cnt_dual, e.cd);
      chk("cnt_single", cnt_single, e.cs);
    end
  end

  // in_ready is combinational: check mid-cycle once inputs have settled.
  always @(negedge clk) begin
    if (rst_n) begin
      bit exp_rdy;
      exp_rdy = (held_q.size() == 0) && (!m_v0 || iss_ready) && !flush;
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    end
  end

  // ---- stimulus -------------------------------------------------------------
  localparam logic [31:0] ADDI  = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] ADD   = 32'h005201B3; // add  x3,x4,x5
  localparam logic [31:0] ADDI2 = 32'h00108113; // addi x2,x1,1
  localparam logic [31:0] LW    = 32'h0003A303;
  localparam logic [31:0] SW    = 32'h0084A023;
  localparam logic [31:0] BEQ   = 32'h00000463;

  task automatic step(input bit v, input bit v1, input logic [31:0] i0,
                      input logic [31:0] i1, input logic [31:0] pc,
                      input bit rdy, input bit fl);
    @(posedge clk);
    #2;
    in_valid = v; in_valid1 = v1; in_instr0 = i0; in_instr1 = i1;
    in_pc = pc; iss_ready = rdy; flush = fl;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 1, 0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [11];
    logic [31:0] r;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h37, 7'h17, 7'h7F, 7'h0B};
    r = $urandom;
    r[6:0]   = ops[$urandom_range(0, 10)];
    r[11:7]  = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    return r;
  endfunction

  initial begin
    rst_n = 0; flush = 0; in_valid = 0; in_valid1 = 0; iss_ready = 1;
    in_instr0 = 0; in_instr1 = 0; in_pc = 0;
    #3;
    chk("rst iss0_valid", {31'd0, iss0_valid}, 32'd0);
    chk("rst iss1_valid", {31'd0, iss1_valid}, 32'd0);
    chk("rst iss0_instr", iss0_instr, 32'd0);
    chk("rst iss0_pc", iss0_pc, 32'd0);
    chk("rst cnt_dual", cnt_dual, 32'd0);
    chk("rst cnt_single", cnt_single, 32'd0);
    @(posedge clk); #2 rst_n = 1;

    // independent pair, RAW split, resource splits
    step(1, 1, ADDI, ADD, 32'h100, 1, 0);   idle(1);
    step(1, 1, ADDI, ADDI2, 32'h100, 1, 0); idle(3);
    step(1, 1, LW, SW, 32'h200, 1, 0);      idle(3);
    step(1, 1, BEQ, ADD, 32'h300, 1, 0);    idle(3);

    // backpressure: three stalled cycles with a new pair waiting
    step(1, 1, ADDI, ADD, 32'h400, 1, 0);
    for (int k = 0; k < 3; k++) step(1, 1, ADD, ADDI, 32'h500, 0, 0);
    step(1, 1, ADD, ADDI, 32'h500, 1, 0);   idle(2);

    // flush while holding the split instruction
    step(1, 1, ADDI, ADDI2, 32'h600, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);              idle(3);

    // flush overriding backpressure on a valid issue register
    step(1, 1, ADDI, ADD, 32'h680, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);              idle(2);

    // single-instruction fetch and PC wrap
    step(1, 0, ADDI, ADDI2, 32'h700, 1, 0); idle(2);
    step(1, 1, ADDI, ADD, 32'hFFFF_FFFC, 1, 0); idle(1);

    // asynchronous reset between edges with valids set
    step(1, 1, ADDI, ADD, 32'h800, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("async iss0_valid", {31'd0, iss0_valid}, 32'd0);
    chk("async iss1_valid", {31'd0, iss1_valid}, 32'd0);
    chk("async cnt_dual", cnt_dual, 32'd0);
    #1 rst_n = 1;
    idle(2);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           rand_instr(), rand_instr(), $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
    idle(4);
    @(posedge clk); #3;
    chk("scoreboard drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dual_issue_ctrl.md
Name: dual_issue_ctrl

Overview:
Issue-stage scheduler for the 2-wide RV32I pipeline, between fetch/decode and the two execute slots. It takes an aligned instruction pair from fetch each cycle. It issues both instructions when they are independent and the resources allow it; otherwise it issues them one at a time, holding instr1 over to the next cycle. Slot0 owns the branch unit and the single LSU port; slot1 is ALU-only plus LUI/AUIPC.

Parameters:
XLEN, 32, instruction and PC width
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  redirect/flush; kills held and registered instructions
in_valid  in  1  fetch pair valid
in_valid1  in  1  second fetch slot holds a real instruction
in_instr0  in  XLEN  older instruction
in_instr1  in  XLEN  younger instruction (PC = in_pc+4)
in_pc  in  XLEN  PC of in_instr0
in_ready  out  1  pair accepted this cycle (in_valid && in_ready)
iss_ready  in  1  execute stage accepts the issue register
iss0_valid  out  1  slot0 valid
iss0_instr  out  XLEN  slot0 instruction
iss0_pc  out  XLEN  slot0 PC
iss1_valid  out  1  slot1 valid
iss1_instr  out  XLEN  slot1 instruction
iss1_pc  out  XLEN  slot1 PC
cnt_dual  out  CNT_W  cycles that issued 2 instructions
cnt_single  out  CNT_W  cycles that issued exactly 1 instruction

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=NORMAL; iss0_valid=0 and iss1_valid=0; iss*_instr, iss*_pc, held regs = 0; counters = 0.
- adv = !iss0_valid || iss_ready. The issue register loads only when adv=1; otherwise it holds all outputs stable.
- Classification by opcode [6:0]:
  - Uses rs1: 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - Uses rs2: 0110011, 0100011, 1100011.
  - Writes rd (rd!=0): 0110011, 0010011, 0000011, 1100111, 1101111, 0110111, 0010111.
  - Mem: 0000011, 0100011. Ctrl: 1100011, 1101111, 1100111.
  - Unknown opcodes count as ALU with no register sources and no rd write.
- can_pair is true only when all of the following hold:
  - in_valid1=1;
  - no RAW: instr0 writes rd and instr1 uses rs1 or rs2 equal to that rd;
  - no WAW: both write the same rd;
  - instr0 is not ctrl;
  - instr1 is neither mem nor ctrl.
- FSM NORMAL:
  - in_ready = adv && !flush.
  - On accept with can_pair: slot0 = instr0/in_pc, slot1 = instr1/in_pc+4, both valid; stay in NORMAL.
  - On accept with !can_pair: slot0 = instr0 only, iss1_valid=0. If in_valid1=1, latch instr1 and in_pc+4 into the held regs and go to HOLD.
  - No accept while adv=1: both valids cleared.
- FSM HOLD:
  - in_ready=0.
  - When adv=1: slot0 = held instruction, iss1_valid=0, go to NORMAL. The held instruction never pairs with the next fetch pair.
- PC arithmetic is modulo 2^XLEN.
- flush has priority over everything:
  - next cycle both valids are 0 and state is NORMAL;
  - in_ready=0 during the flush cycle;
  - flush overrides iss_ready=0.
- Counters:
  - On each cycle where adv=1 and a load occurs, cnt_dual += 1 if both valids are loaded as 1; cnt_single += 1 if exactly one is.
  - Counters wrap at 2^CNT_W and are not cleared by flush.
- Asserting rst_n mid-operation discards the held instruction immediately.

Test Plan:
- Independent pair: in_instr0=0x00500093 (addi x1,x0,5), in_instr1=0x005201B3 (add x3,x4,x5), in_pc=0x100, iss_ready=1 -> next cycle both valid, iss1_pc=0x104, cnt_dual=1, in_ready stays 1.
- RAW pair: 0x00500093 then 0x00108113 (addi x2,x1,1) -> cycle1 slot0 only, in_ready=0. Cycle2 slot0=0x00108113 at pc 0x104, iss1_valid=0. cnt_single=2.
- Resource split: (lw 0x0003A303, sw 0x0084A023) -> issued singly over 2 cycles. Also (beq 0x00000463, add 0x005201B3) -> split, since instr0 is ctrl.
- Backpressure: issue an independent pair, then hold iss_ready=0 for 3 cycles -> outputs unchanged, in_ready=0, counters unchanged. On iss_ready=1 the next pair loads.
- Flush in HOLD: create a RAW split, then assert flush while in HOLD -> next cycle iss0_valid=iss1_valid=0, state NORMAL, and the held instruction is never issued.
- Async reset: drop rst_n between clock edges with valids set -> outputs clear immediately. Also check in_valid1=0 with instr0 only: slot0 issues and there is no HOLD.
